// File: rtl/rq_pkg.sv
// rq_pkg: shared widths and index type for the round-robin drain
package rq_pkg;
    localparam int W_DEF = 32;
    localparam int IDX_W = $clog2(W_DEF);
    localparam int CNT_W = $clog2(W_DEF) + 1;
    typedef logic [IDX_W-1:0] idx_t;
endpackage

// File: rtl/rq_drain_if.sv
// rq_drain_if: set/flush inputs, issue handshake and status of the drain engine
interface rq_drain_if #(parameter int W = rq_pkg::W_DEF);
    localparam int AW = $clog2(W);
    localparam int CW = AW + 1;
    logic          set_vld_i;
    logic [AW-1:0] set_idx_i;
    logic          flush_i;
    logic          issue_vld_o;
    logic [AW-1:0] issue_idx_o;
    logic [W-1:0]  issue_oh_o;
    logic          issue_rdy_i;
    logic [W-1:0]  pend_o;
    logic [CW-1:0] cnt_o;
    logic          err_o;
    modport master (
        output set_vld_i, set_idx_i, flush_i, issue_rdy_i,
        input  issue_vld_o, issue_idx_o, issue_oh_o, pend_o, cnt_o, err_o
    );
    modport slave (
        input  set_vld_i, set_idx_i, flush_i, issue_rdy_i,
        output issue_vld_o, issue_idx_o, issue_oh_o, pend_o, cnt_o, err_o
    );
endinterface

// File: rtl/rq_cffs.sv
// rq_cffs: circular find-first-set starting at pos (rotate, LSB pick, rotate back)
module rq_cffs #(
    parameter int W     = 32,
    parameter bit INFER = 0
) (
    input  logic [W-1:0]         x,
    input  logic [$clog2(W)-1:0] pos,
    output logic [W-1:0]         y,
    output logic [$clog2(W)-1:0] y_enc,
    output logic                 any
);
    localparam int AW = $clog2(W);
    logic [W-1:0] r, pk;
    assign pk  = r & (~r + W'(1));
    assign any = |x;
    generate
        if (INFER) begin : g_inf
            assign r = W'({x, x} >> pos);
            assign y = W'(({pk, pk} << pos) >> W);
        end else begin : g_bs
            logic [W-1:0] sr [AW+1];
            logic [W-1:0] sl [AW+1];
            assign sr[0] = x;
            assign sl[0] = pk;
            for (genvar i = 0; i < AW; i++) begin : g_st
                assign sr[i+1] = pos[i] ? {sr[i][2**i-1:0], sr[i][W-1:2**i]} : sr[i];
                assign sl[i+1] = pos[i] ? {sl[i][W-1-2**i:0], sl[i][W-1:W-2**i]} : sl[i];
            end
            assign r = sr[AW];
            assign y = sl[AW];
        end
    endgenerate
    // binary encode of the one-hot pick
    always_comb begin
        y_enc = '0;
        for (int i = 0; i < W; i++) y_enc = y_enc | (y[i] ? AW'(i) : '0);
    end
endmodule

// File: rtl/rq_drain.sv
// rq_drain: round-robin issue of a pending vector over a valid/ready output register
module rq_drain
    import rq_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter bit INFER = 0
) (
    input  logic     clk,
    input  logic     rst,
    rq_drain_if.slave bus
);
    localparam int AW = $clog2(W);
    localparam int CW = AW + 1;
    logic [W-1:0]  p, p_n, sel_oh;
    logic [AW-1:0] ptr, idx_q, sel;
    logic [CW-1:0] cnt;
    logic          vld, err, any, fire, load, held_hit, dup;
    rq_cffs #(.W(W), .INFER(INFER)) u_cffs (
        .x(p), .pos(ptr), .y(sel_oh), .y_enc(sel), .any(any)
    );
    assign fire     = vld & bus.issue_rdy_i;
    assign load     = any & (~vld | fire);
    assign held_hit = vld & ~fire & (bus.set_idx_i == idx_q);
    assign dup      = bus.set_vld_i & (p[bus.set_idx_i] | held_hit);
    // set wins over the clear of the entry being loaded; a set of the still-held entry is dropped
    always_comb begin
        p_n = (p & ~(load ? sel_oh : '0)) | ((bus.set_vld_i & ~held_hit) ? (W'(1) << bus.set_idx_i) : '0);
    end
    // pending vector, pointer, output register and sticky error
    always_ff @(posedge clk) begin
        if (rst) begin
            p     <= '0;
            ptr   <= '0;
            vld   <= 1'b0;
            idx_q <= '0;
            err   <= 1'b0;
        end else if (bus.flush_i) begin
            p   <= '0;
            ptr <= '0;
            vld <= 1'b0;
        end else begin
            p   <= p_n;
            err <= err | dup;
            if (load) begin
                vld   <= 1'b1;
                idx_q <= sel;
                ptr   <= sel + 1'b1;
            end else if (fire) begin
                vld <= 1'b0;
            end
        end
    end
    // occupancy: pending entries plus the held one
    always_comb begin
        cnt = CW'(vld);
        for (int i = 0; i < W; i++) cnt = cnt + CW'(p[i]);
    end
    assign bus.issue_vld_o = vld;
    assign bus.issue_idx_o = idx_q;
    assign bus.issue_oh_o  = vld ? (W'(1) << idx_q) : '0;
    assign bus.pend_o      = p;
    assign bus.cnt_o       = cnt;
    assign bus.err_o       = err;
endmodule

// File: tb/tb_rq_drain.sv
// tb_rq_drain: directed plan plus randomized run against a behavioural model, W=8
module tb_rq_drain;
    localparam int W = 8;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;
    int   iss[$];
    logic [W-1:0] mp;
    int   mptr, midx;
    logic mv, merr;

    rq_drain_if #(.W(W)) bus ();
    rq_drain #(.W(W), .INFER(0)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // reference: circular search over an array, then apply the documented cycle rules
    task automatic model_upd();
        int  sel;
        bit  found, fire, load, blk, dup;
        if (rst) begin
            mp = '0; mptr = 0; mv = 0; midx = 0; merr = 0;
            return;
        end
        fire = mv && bus.issue_rdy_i;
        found = 0; sel = 0;
        for (int k = 0; k < W; k++) begin
            int j = (mptr + k) % W;
            if (mp[j] && !found) begin found = 1; sel = j; end
        end
        load = found && (!mv || fire);
        blk  = mv && !fire && (int'(bus.set_idx_i) == midx);
        dup  = bus.set_vld_i && (mp[bus.set_idx_i] || blk);
        if (bus.flush_i) begin
            mp = '0; mv = 0; mptr = 0;
        end else begin
            if (dup) merr = 1;
            if (load) begin
                mp[sel] = 0; mv = 1; midx = sel; mptr = (sel + 1) % W;
            end else if (fire) mv = 0;
            if (bus.set_vld_i && !blk) mp[bus.set_idx_i] = 1;
        end
    endtask

    task automatic check_all();
        int c = int'(mv);
        for (int i = 0; i < W; i++) c += int'(mp[i]);
        check("vld", 32'(bus.issue_vld_o), 32'(mv));
        if (mv) check("idx", 32'(bus.issue_idx_o), 32'(midx));
        check("oh", 32'(bus.issue_oh_o), mv ? (32'd1 << midx) : 32'd0);
        check("pend", 32'(bus.pend_o), 32'(mp));
        check("cnt", 32'(bus.cnt_o), 32'(c));
        check("err", 32'(bus.err_o), 32'(merr));
    endtask

    task automatic step();
        if (bus.issue_vld_o && bus.issue_rdy_i) iss.push_back(int'(bus.issue_idx_o));
        @(posedge clk);
        model_upd();
        #1;
        check_all();
    endtask

    task automatic set(input int i);
        bus.set_vld_i = 1'b1;
        bus.set_idx_i = 3'(i);
    endtask

    task automatic check_iss(input string tag, input int exp[$]);
        check({tag, "_n"}, 32'(iss.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < iss.size(); i++) check(tag, 32'(iss[i]), 32'(exp[i]));
        iss.delete();
    endtask

    initial begin
        bus.set_vld_i = 0; bus.set_idx_i = 0; bus.flush_i = 0; bus.issue_rdy_i = 0;
        step(); step();
        rst = 0;
        check("rst_vld", 32'(bus.issue_vld_o), 0);
        check("rst_oh", 32'(bus.issue_oh_o), 0);
        check("rst_cnt", 32'(bus.cnt_o), 0);
        check("rst_err", 32'(bus.err_o), 0);
        // first issue latency
        bus.issue_rdy_i = 1; set(3); step();
        bus.set_vld_i = 0; step();
        check("t1_vld", 32'(bus.issue_vld_o), 1);
        check("t1_idx", 32'(bus.issue_idx_o), 3);
        check("t1_oh", 32'(bus.issue_oh_o), 32'h08);
        check("t1_cnt", 32'(bus.cnt_o), 1);
        step();
        check("t1_vld2", 32'(bus.issue_vld_o), 0);
        check("t1_cnt2", 32'(bus.cnt_o), 0);
        // circular order and wrap
        iss.delete();
        set(1); step(); set(5); step(); set(6); step();
        bus.set_vld_i = 0; step(); step();
        bus.issue_rdy_i = 0;
        set(2); step(); set(0); step(); set(7); step();
        bus.set_vld_i = 0; bus.issue_rdy_i = 1;
        repeat (4) step();
        check_iss("wrap", '{1, 5, 6, 2, 7, 0});
        // backpressure hold
        bus.issue_rdy_i = 0;
        set(2); step(); set(4); step(); set(1); step();
        bus.set_vld_i = 0;
        repeat (5) begin
            step();
            check("hold_idx", 32'(bus.issue_idx_o), 2);
            check("hold_oh", 32'(bus.issue_oh_o), 32'h04);
            check("hold_pend", 32'(bus.pend_o), 32'h12);
        end
        bus.issue_rdy_i = 1;
        repeat (4) step();
        check_iss("bp", '{2, 4, 1});
        // duplicate set of the held entry
        bus.issue_rdy_i = 0;
        set(5); step();
        bus.set_vld_i = 0; step();
        check("dup_err0", 32'(bus.err_o), 0);
        set(5); step();
        bus.set_vld_i = 0;
        check("dup_err", 32'(bus.err_o), 1);
        check("dup_pend", 32'(bus.pend_o), 0);
        check("dup_cnt", 32'(bus.cnt_o), 1);
        step(); step();
        check("dup_sticky", 32'(bus.err_o), 1);
        // flush with concurrent set and fire
        bus.issue_rdy_i = 1; step(); step();
        bus.issue_rdy_i = 0; set(0); step();
        bus.set_vld_i = 0; step();
        bus.flush_i = 1; bus.issue_rdy_i = 1; set(4); step();
        bus.flush_i = 0; bus.set_vld_i = 0;
        check("fl_pend", 32'(bus.pend_o), 0);
        check("fl_vld", 32'(bus.issue_vld_o), 0);
        check("fl_cnt", 32'(bus.cnt_o), 0);
        check("fl_err", 32'(bus.err_o), 1);
        set(4); step();
        bus.set_vld_i = 0; step();
        check("fl_idx", 32'(bus.issue_idx_o), 4);
        step();
        // full occupancy then back-to-back drain
        iss.delete();
        bus.issue_rdy_i = 0;
        for (int i = 0; i < W; i++) begin set(i); step(); end
        bus.set_vld_i = 0; step();
        check("full_cnt", 32'(bus.cnt_o), 8);
        check("full_pend", 32'(bus.pend_o), 32'hFE);
        bus.issue_rdy_i = 1;
        repeat (9) step();
        check_iss("full", '{0, 1, 2, 3, 4, 5, 6, 7});
        check("full_vld", 32'(bus.issue_vld_o), 0);
        check("full_cnt0", 32'(bus.cnt_o), 0);
        // randomized run with occasional reset
        rst = 1; step(); rst = 0;
        repeat (3000) begin
            rst = ($urandom_range(0, 199) == 0);
            bus.set_vld_i = ($urandom_range(0, 9) < 6);
            bus.set_idx_i = 3'($urandom_range(0, W - 1));
            bus.flush_i = ($urandom_range(0, 99) < 3);
            bus.issue_rdy_i = ($urandom_range(0, 9) < 7);
            step();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
